io_port_responder: RTL

// - External-side device for the RISCY 8-bit IO pin bus: the far end of the processor's port (IO/DIRECTION/PORT_RD/PORT_EN).
// - Captures bytes the processor writes out into an RX FIFO for a host; supplies bytes from a host-filled TX FIFO when the processor reads.
// - Used in system benches and FPGA top level in place of the ad hoc tri-state assign on IO.

---
 rtl/io_port_responder_pkg.sv | 32 +++
 rtl/io_port_responder_if.sv | 37 +++
 rtl/io_port_responder_fifo.sv | 53 +++++
 rtl/io_port_responder.sv | 80 ++++++++
 4 files changed

// File: rtl/io_port_responder_pkg.sv
`default_nettype none
// riscy_io_pkg: shared byte type, idle read value and port-mode decode for the
// RISCY IO pin-bus responder.
package riscy_io_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t IDLE_BYTE_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    PM_IDLE    = 2'd0,
    PM_WR      = 2'd1,
    PM_RD      = 2'd2,
    PM_ILLEGAL = 2'd3
  } port_mode_e;

  // A transfer only happens on a strobed cycle; direction and read together is never a transfer.
  function automatic port_mode_e decode_mode(input logic direction,
                                             input logic port_rd,
                                             input logic port_en);
    port_mode_e m;
    m = PM_IDLE;
    if (port_en) begin
      if (direction && port_rd)       m = PM_ILLEGAL;
      else if (direction)             m = PM_WR;
      else if (port_rd)               m = PM_RD;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_port_responder_if.sv
`default_nettype none
// io_port_responder_if: processor strobes, host-side valid/ready FIFO ports,
// occupancy counts and sticky error flags of the IO pin-bus responder.
interface io_port_responder_if #(
  parameter int DEPTH = 8
);
  import riscy_io_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          direction;
  logic          port_rd;
  logic          port_en;
  byte_t         tx_data;
  logic          tx_valid;
  logic          tx_ready;
  byte_t         rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;
  logic          ovf;
  logic          udf;
  logic          clr_flags;

  modport master (
    output direction, port_rd, port_en, tx_data, tx_valid, rx_ready, clr_flags,
    input  tx_ready, rx_data, rx_valid, rx_count, tx_count, ovf, udf
  );

  modport slave (
    input  direction, port_rd, port_en, tx_data, tx_valid, rx_ready, clr_flags,
    output tx_ready, rx_data, rx_valid, rx_count, tx_count, ovf, udf
  );

endinterface
`default_nettype wire

// File: rtl/io_port_responder_fifo.sv
`default_nettype none
// io_sync_fifo: register-based synchronous byte FIFO; pop on empty is ignored,
// push on full is accepted only when a pop frees the slot in the same cycle.
module io_sync_fifo
  import riscy_io_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       push,
  input  wire logic                       pop,
  input  wire byte_t                      din,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(DEPTH):0]          count,
  output byte_t                           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  byte_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           pop_ok;
  logic           push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_port_responder.sv
`default_nettype none
// io_port_responder: far-end device on the RISCY 8-bit IO pin bus, queuing
// processor writes for a host (RX) and serving processor reads from a host-filled queue (TX).
module io_port_responder
  import riscy_io_pkg::*;
#(
  parameter int    DEPTH     = 8,
  parameter byte_t IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  wire logic        clk,
  input  wire logic        rst,
  inout  wire [7:0]        io,
  io_port_responder_if.slave bus
);

  port_mode_e              mode;
  logic                    rx_full, rx_empty, tx_full, tx_empty;
  logic [$clog2(DEPTH):0]  rx_count, tx_count;
  byte_t                   rx_head, tx_head;
  logic                    tx_ready;
  logic                    drive;
  logic                    ovf, udf;
  logic                    ovf_set, udf_set;

  assign mode = decode_mode(bus.direction, bus.port_rd, bus.port_en);

  io_sync_fifo #(.DEPTH(DEPTH)) rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (mode == PM_WR),
    .pop   (bus.rx_ready),
    .din   (io),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  io_sync_fifo #(.DEPTH(DEPTH)) tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.tx_valid && tx_ready),
    .pop   (mode == PM_RD),
    .din   (bus.tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_head)
  );

  // A full TX queue still takes a host byte when the processor drains one that cycle.
  assign tx_ready = !tx_full || (mode == PM_RD && !tx_empty);

  // Reset gates the driver so the pins are released the moment reset asserts.
  assign drive = rst && bus.port_rd && !bus.direction;
  assign io    = drive ? (tx_empty ? IDLE_BYTE : tx_head) : 8'bz;

  assign ovf_set = (mode == PM_WR) && rx_full && !bus.rx_ready;
  assign udf_set = (mode == PM_RD) && tx_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf_set || (ovf && !bus.clr_flags);
      udf <= udf_set || (udf && !bus.clr_flags);
    end
  end

  assign bus.tx_ready = tx_ready;
  assign bus.rx_data  = rx_head;
  assign bus.rx_valid = !rx_empty;
  assign bus.rx_count = rx_count;
  assign bus.tx_count = tx_count;
  assign bus.ovf      = ovf;
  assign bus.udf      = udf;

endmodule
`default_nettype wire
